// File: rtl/pixel_stream_sink_pkg.sv
// Shared video parameters and FSM encodings for the
// pixel stream sink and its neighbouring video blocks.
package pixel_stream_sink_pkg;

  localparam int DEF_X_SIZE = 640;
  localparam int DEF_Y_SIZE = 480;
  localparam int DEF_DATA_W = 24;

  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } sink_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready skid buffer with registered outputs.
// Entry order: out register first, skid register second.
module axis_skid_buffer #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] out_q, out_d;
  logic         ov_q, ov_d;
  logic [W-1:0] sk_q, sk_d;
  logic         sv_q, sv_d;
  logic         push, pop;

  assign in_ready  = !sv_q;
  assign out_data  = out_q;
  assign out_valid = ov_q;

  // Next entry contents from push/pop; skid only fills while out stalls.
  always_comb begin
    out_d = out_q;
    ov_d  = ov_q;
    sk_d  = sk_q;
    sv_d  = sv_q;
    push  = in_valid && !sv_q;
    pop   = ov_q && out_ready;
    if (pop) begin
      if (sv_q) begin
        out_d = sk_q;
        sv_d  = 1'b0;
      end else begin
        ov_d = push;
        if (push) out_d = in_data;
      end
    end else if (!ov_q) begin
      ov_d = push;
      if (push) out_d = in_data;
    end else if (push) begin
      sk_d = in_data;
      sv_d = 1'b1;
    end
  end

  // Buffer registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_q <= '0;
      ov_q  <= 1'b0;
      sk_q  <= '0;
      sv_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      ov_q  <= ov_d;
      sk_q  <= sk_d;
      sv_q  <= sv_d;
    end
  end

endmodule

// File: rtl/pixel_stream_sink.sv
// Raster pixel stream receiver: locks to SOF, tracks
// col/row, checks framing and re-emits AXI4-Stream video.
module pixel_stream_sink
  import pixel_stream_sink_pkg::*;
#(
  parameter int X_SIZE = DEF_X_SIZE,
  parameter int Y_SIZE = DEF_Y_SIZE,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_first,
  input  logic              s_lastx,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [15:0]       frame_count,
  output logic              locked,
  output logic              err_sof,
  output logic              err_eol
);

  localparam int CW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int RW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(X_SIZE - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(Y_SIZE - 1);

  sink_state_t     state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [15:0]     frame_q, frame_d;
  logic            locked_q, locked_d;
  logic            err_sof_q, err_sof_d;
  logic            err_eol_q, err_eol_d;

  logic            sb_in_ready;
  logic            acc;
  logic            push;
  logic            p_user, p_last;
  logic            take;
  logic [CW-1:0]   base_c;
  logic [RW-1:0]   base_r;
  logic            at_org, last_col;
  logic [DATA_W+1:0] sb_out;

  assign at_org   = (col_q == '0) && (row_q == '0);
  assign last_col = (col_q == COL_MAX);

  // Hunting drops non-SOF beats even while the buffer is full.
  assign s_ready = sb_in_ready ||
                   (state_q == HUNT && !s_first);
  assign acc     = s_valid && s_ready;

  // Framing checks, push decision and counter advance.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    frame_d   = frame_q;
    err_sof_d = 1'b0;
    err_eol_d = 1'b0;
    push      = 1'b0;
    p_user    = 1'b0;
    p_last    = 1'b0;
    take      = 1'b0;
    base_c    = '0;
    base_r    = '0;
    unique case (state_q)
      HUNT: begin
        if (acc && s_first) begin
          push    = 1'b1;
          p_user  = 1'b1;
          p_last  = (X_SIZE == 1);
          take    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (acc) begin
          if (s_first && !at_org) begin
            err_sof_d = 1'b1;
            push      = 1'b1;
            p_user    = 1'b1;
            p_last    = (X_SIZE == 1);
            take      = 1'b1;
          end else if (s_lastx != last_col) begin
            err_eol_d = 1'b1;
            col_d     = '0;
            row_d     = '0;
            state_d   = HUNT;
          end else begin
            push   = 1'b1;
            p_user = at_org;
            p_last = last_col;
            base_c = col_q;
            base_r = row_q;
            take   = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (take) begin
      if (base_c == COL_MAX) begin
        col_d = '0;
        if (base_r == ROW_MAX) begin
          row_d   = '0;
          frame_d = frame_q + 16'd1;
        end else begin
          row_d = base_r + RW'(1);
        end
      end else begin
        col_d = base_c + CW'(1);
        row_d = base_r;
      end
    end
    locked_d = (state_d == RUN);
  end

  // Control state, counters and status flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= HUNT;
      col_q     <= '0;
      row_q     <= '0;
      frame_q   <= '0;
      locked_q  <= 1'b0;
      err_sof_q <= 1'b0;
      err_eol_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      frame_q   <= frame_d;
      locked_q  <= locked_d;
      err_sof_q <= err_sof_d;
      err_eol_q <= err_eol_d;
    end
  end

  axis_skid_buffer #(
    .W (DATA_W + 2)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   ({p_user, p_last, s_data}),
    .in_valid  (push),
    .in_ready  (sb_in_ready),
    .out_data  (sb_out),
    .out_valid (m_tvalid),
    .out_ready (m_tready)
  );

  assign m_tuser     = sb_out[DATA_W+1];
  assign m_tlast     = sb_out[DATA_W];
  assign m_tdata     = sb_out[DATA_W-1:0];
  assign frame_count = frame_q;
  assign locked      = locked_q;
  assign err_sof     = err_sof_q;
  assign err_eol     = err_eol_q;

endmodule

// File: tb/tb_pixel_stream_sink.sv
// Scoreboard bench for pixel_stream_sink with a 4x3
// frame and 8-bit pixels.
module tb_pixel_stream_sink;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_first = 1'b0;
  logic       s_lastx = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] m_tdata;
  logic       m_tuser;
  logic       m_tlast;
  logic       m_tvalid;
  logic       m_tready = 1'b1;
  logic [15:0] frame_count;
  logic       locked;
  logic       err_sof;
  logic       err_eol;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  logic       prev_stall = 1'b0;
  logic [9:0] prev_out = '0;

  always #5 clk = ~clk;

  pixel_stream_sink #(
    .X_SIZE (4),
    .Y_SIZE (3),
    .DATA_W (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_data      (s_data),
    .s_first     (s_first),
    .s_lastx     (s_lastx),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_tdata     (m_tdata),
    .m_tuser     (m_tuser),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .frame_count (frame_count),
    .locked      (locked),
    .err_sof     (err_sof),
    .err_eol     (err_eol)
  );

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // Monitor: pop and compare each output beat, and
  // check that stalled outputs hold steady.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_tvalid ||
            {m_tuser, m_tlast, m_tdata} !== prev_out) begin
          errors++;
          $display("FAIL hold: got v=%0b %0h expected %0h",
                   m_tvalid, {m_tuser, m_tlast, m_tdata},
                   prev_out);
        end
      end
      prev_stall <= m_tvalid && !m_tready;
      prev_out   <= {m_tuser, m_tlast, m_tdata};
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: got %0h expected none",
                   {m_tuser, m_tlast, m_tdata});
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if ({m_tuser, m_tlast, m_tdata} !== e) begin
            errors++;
            $display("FAIL beat: got %0h expected %0h",
                     {m_tuser, m_tlast, m_tdata}, e);
          end
        end
      end
    end
  end

  // Present one beat from posedge+1, wait for s_ready,
  // then check the error pulses from its acceptance.
  task automatic send(input logic [7:0] d,
                      input logic f,
                      input logic l,
                      input logic eo,
                      input logic eu,
                      input logic el,
                      input logic esof,
                      input logic eeol,
                      input logic rdy1);
    int n;
    s_data  = d;
    s_first = f;
    s_lastx = l;
    s_valid = 1'b1;
    @(negedge clk);
    if (rdy1) chk("hunt_ready", 32'(s_ready), 32'd1);
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      chk("send_timeout", 32'(s_ready), 32'd1);
    end else if (eo) begin
      exp_q.push_back({eu, el, d});
    end
    @(posedge clk);
    #1;
    chk("err_sof", 32'(err_sof), 32'(esof));
    chk("err_eol", 32'(err_eol), 32'(eeol));
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_first = 1'b0;
    s_lastx = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] base);
    for (int i = 0; i < 12; i++) begin
      send(base + 8'(i), i == 0, (i % 4) == 3,
           1'b1, i == 0, (i % 4) == 3, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    resetn  = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    // T1: reset state and one clean frame
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'({m_tuser, m_tlast, m_tdata}), 32'd0);
    chk("rst_frames", 32'(frame_count), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'({err_sof, err_eol}), 32'd0);
    resetn = 1'b1;
    send(8'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
         1'b0, 1'b0, 1'b0);
    chk("t1_latency", 32'(m_tvalid), 32'd1);
    for (int i = 1; i < 12; i++) begin
      send(8'(i), 1'b0, (i % 4) == 3, 1'b1, 1'b0,
           (i % 4) == 3, 1'b0, 1'b0, 1'b0);
    end
    idle(3);
    drain();
    chk("t1_frames", 32'(frame_count), 32'd1);

    // T2: discard beats before SOF, then lock
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
           1'b0, 1'b0, 1'b1);
    end
    chk("t2_unlocked", 32'(locked), 32'd0);
    send(8'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
         1'b0, 1'b0, 1'b1);
    chk("t2_locked", 32'(locked), 32'd1);
    for (int i = 1; i < 12; i++) begin
      send(8'(5 + i), 1'b0, (i % 4) == 3, 1'b1, 1'b0,
           (i % 4) == 3, 1'b0, 1'b0, 1'b0);
    end
    idle(3);
    drain();
    chk("t2_frames", 32'(frame_count), 32'd1);

    // T3: downstream stall for 10 cycles
    fork
      send_frame(8'd20);
      begin
        m_tready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t3_full_ready", 32'(s_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        m_tready = 1'b1;
      end
    join
    idle(3);
    drain();
    chk("t3_frames", 32'(frame_count), 32'd2);

    // T4: SOF at col 2 row 1 resyncs counters
    for (int i = 0; i < 4; i++) begin
      send(8'(40 + i), i == 0, i == 3, 1'b1, i == 0,
           i == 3, 1'b0, 1'b0, 1'b0);
    end
    send(8'd44, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0);
    send(8'd45, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0);
    send(8'd46, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
         1'b1, 1'b0, 1'b0);
    send(8'd47, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0);
    send(8'd48, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0);
    send(8'd49, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
         1'b0, 1'b0, 1'b0);
    chk("t4_frames_hold", 32'(frame_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      send(8'(50 + i), 1'b0, (i % 4) == 3, 1'b1, 1'b0,
           (i % 4) == 3, 1'b0, 1'b0, 1'b0);
    end
    idle(3);
    drain();
    chk("t4_frames", 32'(frame_count), 32'd3);

    // T5: early lastx drops the beat and unlocks
    send(8'd60, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
         1'b0, 1'b0, 1'b0);
    send(8'd61, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b1, 1'b0);
    chk("t5_unlocked", 32'(locked), 32'd0);
    send(8'd62, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b1);
    send(8'd63, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b1);
    chk("t5_still_unlocked", 32'(locked), 32'd0);
    send_frame(8'd64);
    idle(3);
    drain();
    chk("t5_frames", 32'(frame_count), 32'd4);

    // T6: reset mid-frame with two beats buffered
    m_tready = 1'b0;
    send(8'd80, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
         1'b0, 1'b0, 1'b0);
    send(8'd81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0);
    idle(1);
    chk("t6_full_ready", 32'(s_ready), 32'd0);
    do_reset();
    chk("t6_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_frames", 32'(frame_count), 32'd0);
    chk("t6_locked", 32'(locked), 32'd0);
    m_tready = 1'b1;
    send_frame(8'd90);
    idle(3);
    drain();
    chk("t6_relock_frames", 32'(frame_count), 32'd1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
